// File: rtl/async_fifo.sv
// async_fifo: dual-clock FIFO carrying DATA_WIDTH-bit words from the wr_clk
// domain to the rd_clk domain. Binary pointers are ADDR_WIDTH+1 bits wide and
// cross domains as Gray code through two-flop synchronizers. Full and empty
// are registered and pessimistic in their own domain.
// Optional build macro ASYNC_FIFO_ASSERT_EN adds simulation overflow/underflow
// checks and internal attempt counters; behaviour is otherwise identical.
module async_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int OUTPUT_REG = 1
) (
    input  logic                  wr_clk,
    input  logic                  rd_clk,
    input  logic                  rst_glb_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full_out,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty_out
);

    localparam int PW = ADDR_WIDTH + 1;
    // Full when the write Gray pointer equals the read Gray pointer with its
    // two most significant bits inverted (one full lap ahead).
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_WIDTH - 1);

    // Storage depth must be an exact power of two of the address width.
    if (DEPTH != (2 ** ADDR_WIDTH)) begin : g_depth_check
        $error("async_fifo: DEPTH (%0d) must equal 2**ADDR_WIDTH (%0d)", DEPTH, 2 ** ADDR_WIDTH);
    end

    // ------------------------------------------------------------------
    // Reset synchronizers: assert asynchronously, release on the domain clock
    // ------------------------------------------------------------------
    logic [1:0] wr_rst_sync_reg;
    logic [1:0] rd_rst_sync_reg;
    logic       wr_rst_n;
    logic       rd_rst_n;

    // Two-flop release synchronizer for the write domain.
    always_ff @(posedge wr_clk or negedge rst_glb_n) begin
        if (!rst_glb_n) wr_rst_sync_reg <= 2'b00;
        else            wr_rst_sync_reg <= {wr_rst_sync_reg[0], 1'b1};
    end

    // Two-flop release synchronizer for the read domain.
    always_ff @(posedge rd_clk or negedge rst_glb_n) begin
        if (!rst_glb_n) rd_rst_sync_reg <= 2'b00;
        else            rd_rst_sync_reg <= {rd_rst_sync_reg[0], 1'b1};
    end

    assign wr_rst_n = wr_rst_sync_reg[1];
    assign rd_rst_n = rd_rst_sync_reg[1];

    // ------------------------------------------------------------------
    // Storage (contents deliberately not reset)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Write domain
    // ------------------------------------------------------------------
    logic [PW-1:0]         wbin_reg, wbin_next;
    logic [PW-1:0]         wgray_reg, wgray_next;
    logic [PW-1:0]         rgray_sync1_reg, rgray_sync2_reg;
    logic                  full_reg, full_next;
    logic                  wr_accept;
    logic [ADDR_WIDTH-1:0] waddr;

    assign wr_accept  = wr_en && !full_reg;
    assign waddr      = wbin_reg[ADDR_WIDTH-1:0];
    assign wbin_next  = wbin_reg + PW'(wr_accept);
    assign wgray_next = wbin_next ^ (wbin_next >> 1);
    assign full_next  = (wgray_next == (rgray_sync2_reg ^ FULL_MASK));
    assign full_out   = full_reg;

    // Write pointers, full flag and read-pointer synchronizer.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wbin_reg        <= '0;
            wgray_reg       <= '0;
            rgray_sync1_reg <= '0;
            rgray_sync2_reg <= '0;
            full_reg        <= 1'b0;
        end else begin
            wbin_reg        <= wbin_next;
            wgray_reg       <= wgray_next;
            rgray_sync1_reg <= rgray_reg;
            rgray_sync2_reg <= rgray_sync1_reg;
            full_reg        <= full_next;
        end
    end

    // Store the accepted word at the current write address.
    always_ff @(posedge wr_clk) begin
        if (wr_accept) mem[waddr] <= wr_data;
    end

    // ------------------------------------------------------------------
    // Read domain
    // ------------------------------------------------------------------
    logic [PW-1:0]         rbin_reg, rbin_next;
    logic [PW-1:0]         rgray_reg, rgray_next;
    logic [PW-1:0]         wgray_sync1_reg, wgray_sync2_reg;
    logic                  empty_reg, empty_next;
    logic                  rd_accept;
    logic [ADDR_WIDTH-1:0] raddr;

    assign rd_accept  = rd_en && !empty_reg;
    assign raddr      = rbin_reg[ADDR_WIDTH-1:0];
    assign rbin_next  = rbin_reg + PW'(rd_accept);
    assign rgray_next = rbin_next ^ (rbin_next >> 1);
    assign empty_next = (rgray_next == wgray_sync2_reg);
    assign empty_out  = empty_reg;

    // Read pointers, empty flag and write-pointer synchronizer.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rbin_reg        <= '0;
            rgray_reg       <= '0;
            wgray_sync1_reg <= '0;
            wgray_sync2_reg <= '0;
            empty_reg       <= 1'b1;
        end else begin
            rbin_reg        <= rbin_next;
            rgray_reg       <= rgray_next;
            wgray_sync1_reg <= wgray_reg;
            wgray_sync2_reg <= wgray_sync1_reg;
            empty_reg       <= empty_next;
        end
    end

    if (OUTPUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] rd_data_reg;

        // Capture the head word on the accepting edge; hold otherwise.
        always_ff @(posedge rd_clk or negedge rd_rst_n) begin
            if (!rd_rst_n)      rd_data_reg <= '0;
            else if (rd_accept) rd_data_reg <= mem[raddr];
        end

        assign rd_data = rd_data_reg;
    end else begin : g_out_comb
        // Head of FIFO presented directly; valid whenever empty_out is low.
        assign rd_data = mem[raddr];
    end

`ifdef ASYNC_FIFO_ASSERT_EN
    logic [31:0] overflow_cnt;
    logic [31:0] underflow_cnt;

    // Count and report write attempts made while full.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            overflow_cnt <= '0;
        end else if (wr_en && full_reg) begin
            overflow_cnt <= overflow_cnt + 32'd1;
            $error("async_fifo: write attempted while full");
        end
    end

    // Count and report read attempts made while empty.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            underflow_cnt <= '0;
        end else if (rd_en && empty_reg) begin
            underflow_cnt <= underflow_cnt + 32'd1;
            $error("async_fifo: read attempted while empty");
        end
    end
`else
`endif

endmodule

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed self-checking bench for async_fifo with default
// parameters (DEPTH 16, 8-bit words, registered read data).
`timescale 1ns/100ps
module tb_async_fifo;

    logic       wr_clk    = 1'b0;
    logic       rd_clk    = 1'b0;
    logic       rst_glb_n = 1'b0;
    logic       wr_en     = 1'b0;
    logic [7:0] wr_data   = 8'h00;
    logic       rd_en     = 1'b0;
    logic       full_out;
    logic       empty_out;
    logic [7:0] rd_data;

    int checks   = 0;
    int failures = 0;
    int wcount   = 0;
    int rcount   = 0;
    int wcyc     = 0;
    int rcyc     = 0;
    bit pend     = 1'b0;

    localparam int WRAP_WORDS = 3 * 16 + 5;

    always #5   wr_clk = ~wr_clk;
    always #3.5 rd_clk = ~rd_clk;

    async_fifo #(
        .DEPTH(16), .DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG(1)
    ) dut (
        .wr_clk(wr_clk), .rd_clk(rd_clk), .rst_glb_n(rst_glb_n),
        .wr_en(wr_en), .wr_data(wr_data), .full_out(full_out),
        .rd_en(rd_en), .rd_data(rd_data), .empty_out(empty_out)
    );

    function automatic logic [7:0] pattern(int i);
        return 8'(i * 37 + 5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for empty_out to drop, then confirm it did.
    task automatic wait_not_empty(input string tag);
        for (int k = 0; k < 20; k++) begin
            @(negedge rd_clk);
            if (!empty_out) break;
        end
        check(tag, 32'(empty_out), 32'd0);
    endtask

    initial begin
        // Reset state while held and after release
        #10;
        check("rst_full", 32'(full_out), 32'd0);
        check("rst_empty", 32'(empty_out), 32'd1);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        #10 rst_glb_n = 1'b1;
        repeat (4) @(posedge wr_clk);
        #1;
        check("rel_full", 32'(full_out), 32'd0);
        check("rel_empty", 32'(empty_out), 32'd1);

        // Fill 0..15; full only after the 16th write
        @(negedge wr_clk);
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            @(negedge wr_clk);
            check($sformatf("fill_full_%0d", i), 32'(full_out), 32'(i == 15));
        end
        // Writes while full must be dropped
        wr_data = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            @(negedge wr_clk);
            check("overflow_full", 32'(full_out), 32'd1);
        end
        wr_en = 1'b0;

        // Drain 0..15; empty only after the 16th read
        wait_not_empty("drain_ready");
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge rd_clk);
            #1;
            check($sformatf("drain_data_%0d", i), 32'(rd_data), 32'(i));
            check($sformatf("drain_empty_%0d", i), 32'(empty_out), 32'(i == 15));
        end
        rd_en = 1'b0;
        repeat (5) @(negedge wr_clk);
        check("full_release", 32'(full_out), 32'd0);

        // Partial: write 0x10..0x13, read two
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(16 + i);
            @(negedge wr_clk);
        end
        wr_en = 1'b0;
        wait_not_empty("partial_ready");
        rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge rd_clk);
            #1;
            check("partial_data", 32'(rd_data), 32'(16 + i));
            check("partial_empty", 32'(empty_out), 32'd0);
        end
        rd_en = 1'b0;
        repeat (3) @(posedge rd_clk);
        #1;
        check("partial_hold", 32'(rd_data), 32'h11);
        check("partial_empty_hold", 32'(empty_out), 32'd0);
        @(negedge rd_clk);
        rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge rd_clk);
            #1;
            check("tail_data", 32'(rd_data), 32'(18 + i));
            check("tail_empty", 32'(empty_out), 32'(i == 1));
        end
        // Read while empty is ignored and data holds
        @(posedge rd_clk);
        #1;
        check("underflow_hold", 32'(rd_data), 32'h13);
        check("underflow_empty", 32'(empty_out), 32'd1);
        rd_en = 1'b0;

        // Wrap: concurrent random traffic across several pointer laps
        fork
            begin
                while (wcount < WRAP_WORDS && wcyc < 5000) begin
                    @(negedge wr_clk);
                    wcyc++;
                    if ($urandom_range(0, 1) == 1 && !full_out) begin
                        wr_en   = 1'b1;
                        wr_data = pattern(wcount);
                        wcount++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge wr_clk);
                wr_en = 1'b0;
            end
            begin
                while (rcount < WRAP_WORDS && rcyc < 8000) begin
                    @(negedge rd_clk);
                    rcyc++;
                    if (pend) begin
                        check($sformatf("wrap_data_%0d", rcount), 32'(rd_data), 32'(pattern(rcount)));
                        rcount++;
                        pend = 1'b0;
                    end
                    if (rcount < WRAP_WORDS && $urandom_range(0, 1) == 1 && !empty_out) begin
                        rd_en = 1'b1;
                        pend  = 1'b1;
                    end else begin
                        rd_en = 1'b0;
                    end
                end
                rd_en = 1'b0;
            end
        join
        check("wrap_count", 32'(rcount), 32'(WRAP_WORDS));
        repeat (4) @(negedge rd_clk);
        check("wrap_empty", 32'(empty_out), 32'd1);

        // Mid-operation reset with 7 words stored
        @(negedge wr_clk);
        for (int i = 0; i < 7; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h60 + i);
            @(negedge wr_clk);
        end
        wr_en = 1'b0;
        wait_not_empty("midrst_ready");
        #2 rst_glb_n = 1'b0;
        #1;
        check("midrst_empty", 32'(empty_out), 32'd1);
        check("midrst_full", 32'(full_out), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        #20 rst_glb_n = 1'b1;
        repeat (4) @(negedge wr_clk);
        check("post_rst_empty", 32'(empty_out), 32'd1);
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        @(negedge wr_clk);
        wr_en = 1'b0;
        wait_not_empty("post_rst_ready");
        rd_en = 1'b1;
        @(posedge rd_clk);
        #1;
        check("post_rst_data", 32'(rd_data), 32'hA5);
        check("post_rst_drained", 32'(empty_out), 32'd1);
        rd_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
